// File: rtl/ref_mem_burst_responder_pkg.sv
// Shared widths and FSM encoding for the ref_mem burst responder.
package ref_mem_burst_responder_pkg;

  localparam int unsigned ExtBufMemAddrWidth = 16;
  localparam int unsigned ExtBufMemDataWidth = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StData  = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/ref_mem_burst_responder.sv
// Serves one ref_mem burst read by issuing Avalon-MM sub-bursts of at most AVM_MAX_BURST words
// and forwarding each returned beat one cycle later.
module ref_mem_burst_responder
  import ref_mem_burst_responder_pkg::*;
#(
  parameter int unsigned ADDR_W        = ExtBufMemAddrWidth,
  parameter int unsigned DATA_W        = ExtBufMemDataWidth,
  parameter int unsigned AVM_MAX_BURST = 16,
  parameter int unsigned BYTE_SHIFT    = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ena_i,
  input  logic                       ref_mem_burst_i,
  input  logic                       ref_mem_rd_i,
  input  logic [ADDR_W-1:0]          ref_mem_addr_i,
  input  logic [4:0]                 ref_mem_burst_len_minus1_i,
  output logic                       ref_mem_ready_o,
  output logic                       ref_mem_valid_o,
  output logic [DATA_W-1:0]          ref_mem_data_o,
  output logic [ADDR_W+BYTE_SHIFT-1:0] avm_address_o,
  output logic                       avm_read_o,
  output logic [5:0]                 avm_burstcount_o,
  input  logic                       avm_waitrequest_i,
  input  logic [DATA_W-1:0]          avm_readdata_i,
  input  logic                       avm_readdatavalid_i
);

  localparam logic [5:0] MaxBurst = 6'(AVM_MAX_BURST);

  state_e                        state_q;
  logic [ADDR_W-1:0]             addr_q;
  logic [5:0]                    rem_q;
  logic [5:0]                    beats_q;
  logic                          ready_q;
  logic                          valid_q;
  logic [DATA_W-1:0]             data_q;
  logic                          avm_read_q;
  logic [ADDR_W+BYTE_SHIFT-1:0]  avm_address_q;
  logic [5:0]                    burstcount_q;

  logic                          accept;
  logic [5:0]                    req_len;
  logic [5:0]                    rem_d;
  logic [ADDR_W-1:0]             addr_d;

  function automatic logic [5:0] clip_burst(input logic [5:0] n);
    return (n > MaxBurst) ? MaxBurst : n;
  endfunction

  function automatic logic [ADDR_W+BYTE_SHIFT-1:0] byte_addr(input logic [ADDR_W-1:0] a);
    return (ADDR_W+BYTE_SHIFT)'(a) << BYTE_SHIFT;
  endfunction

  // ready_q is only high in StIdle, so it doubles as the idle qualifier.
  assign accept  = ena_i & ref_mem_rd_i & ready_q;
  assign req_len = ref_mem_burst_i ? ({1'b0, ref_mem_burst_len_minus1_i} + 6'd1) : 6'd1;
  assign rem_d   = rem_q - burstcount_q;
  assign addr_d  = addr_q + ADDR_W'(burstcount_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      rem_q         <= '0;
      beats_q       <= '0;
      ready_q       <= 1'b1;
      valid_q       <= 1'b0;
      data_q        <= '0;
      avm_read_q    <= 1'b0;
      avm_address_q <= '0;
      burstcount_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q        <= ref_mem_addr_i;
            rem_q         <= req_len;
            ready_q       <= 1'b0;
            avm_read_q    <= 1'b1;
            avm_address_q <= byte_addr(ref_mem_addr_i);
            burstcount_q  <= clip_burst(req_len);
            state_q       <= StIssue;
          end
        end
        StIssue: begin
          if (!avm_waitrequest_i) begin
            avm_read_q <= 1'b0;
            beats_q    <= burstcount_q;
            state_q    <= StData;
          end
        end
        StData: begin
          if (avm_readdatavalid_i) begin
            valid_q <= 1'b1;
            data_q  <= avm_readdata_i;
            beats_q <= beats_q - 6'd1;
            if (beats_q == 6'd1) begin
              rem_q  <= rem_d;
              addr_q <= addr_d;
              // Next sub-burst goes out straight from the last beat, keeping one command in flight.
              if (rem_d != 6'd0) begin
                avm_read_q    <= 1'b1;
                avm_address_q <= byte_addr(addr_d);
                burstcount_q  <= clip_burst(rem_d);
                state_q       <= StIssue;
              end else begin
                state_q <= StDone;
              end
            end
          end
        end
        StDone: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ref_mem_ready_o  = ready_q;
  assign ref_mem_valid_o  = valid_q;
  assign ref_mem_data_o   = data_q;
  assign avm_read_o       = avm_read_q;
  assign avm_address_o    = avm_address_q;
  assign avm_burstcount_o = burstcount_q;

endmodule

// File: tb/tb_ref_mem_burst_responder.sv
// Randomized bench: an Avalon slave model serves words from a hashed memory; a queue-based
// reference predicts every returned word and every sub-burst command.
module tb_ref_mem_burst_responder;

  localparam int unsigned AW        = 10;
  localparam int unsigned DW        = 32;
  localparam int unsigned MaxBurst  = 16;
  localparam int unsigned ByteShift = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  ena = 1'b0;
  logic                  burst = 1'b0;
  logic                  rd = 1'b0;
  logic [AW-1:0]         addr = '0;
  logic [4:0]            lenm1 = '0;
  logic                  ready;
  logic                  valid;
  logic [DW-1:0]         data;
  logic [AW+ByteShift-1:0] avm_address;
  logic                  avm_read;
  logic [5:0]            avm_bc;
  logic                  waitreq = 1'b0;
  logic [DW-1:0]         rdata = '0;
  logic                  rdvalid = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0;
  int v0 = 0;
  int req_len = 0;
  int slv_lat = 2;
  int gap_pct = 0;
  int stall_pct = 0;
  int force_wait = 0;

  logic [DW-1:0] exp_data_q[$];
  int            exp_cmd_addr_q[$];
  int            exp_cmd_len_q[$];

  always #5 clk = ~clk;

  ref_mem_burst_responder #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .AVM_MAX_BURST (MaxBurst),
    .BYTE_SHIFT    (ByteShift)
  ) dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .ena_i                      (ena),
    .ref_mem_burst_i            (burst),
    .ref_mem_rd_i               (rd),
    .ref_mem_addr_i             (addr),
    .ref_mem_burst_len_minus1_i (lenm1),
    .ref_mem_ready_o            (ready),
    .ref_mem_valid_o            (valid),
    .ref_mem_data_o             (data),
    .avm_address_o              (avm_address),
    .avm_read_o                 (avm_read),
    .avm_burstcount_o           (avm_bc),
    .avm_waitrequest_i          (waitreq),
    .avm_readdata_i             (rdata),
    .avm_readdatavalid_i        (rdvalid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Odd multiplier makes every address in the AW-bit space hold a distinct word.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return DW'(32'(a) * 32'h9E37_79B1 + 32'h0135_7BDF);
  endfunction

  // Reference: word sequence and sub-burst split derived from address/length arithmetic.
  task automatic push_model(input logic [AW-1:0] a, input int len);
    int off;
    int cnt;
    logic [AW-1:0] t;
    for (int i = 0; i < len; i++) begin
      t = a + AW'(i);
      exp_data_q.push_back(mem_word(t));
    end
    off = 0;
    while (off < len) begin
      cnt = (len - off > int'(MaxBurst)) ? int'(MaxBurst) : (len - off);
      t = a + AW'(off);
      exp_cmd_addr_q.push_back(int'(t));
      exp_cmd_len_q.push_back(cnt);
      off += cnt;
    end
  endtask

  // Monitor: every forwarded word must be the next one the model predicts.
  initial begin
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        n_valid++;
        if (exp_data_q.size() == 0) check("stray_valid", 64'(valid), 64'(0));
        else check("data", 64'(data), 64'(exp_data_q.pop_front()));
      end
    end
  end

  // Avalon slave model with latency, stalls and data gaps.
  initial begin
    int beats_left;
    int lat;
    logic [AW-1:0] sa;
    logic stalled;
    logic [AW+ByteShift-1:0] hold_a;
    logic [5:0] hold_bc;
    logic [AW+ByteShift-1:0] exp_a;
    beats_left = 0;
    lat = 0;
    sa = '0;
    stalled = 1'b0;
    hold_a = '0;
    hold_bc = '0;
    forever begin
      @(negedge clk);
      rdvalid = 1'b0;
      if (stalled && !rst) begin
        check("hold_read", 64'(avm_read), 64'(1));
        check("hold_addr", 64'(avm_address), 64'(hold_a));
        check("hold_bc", 64'(avm_bc), 64'(hold_bc));
      end
      stalled = 1'b0;
      if (beats_left > 0) begin
        if (lat > 0) lat--;
        else if ($urandom_range(99) >= gap_pct) begin
          rdvalid = 1'b1;
          rdata = mem_word(sa);
          sa = sa + 1'b1;
          beats_left--;
        end
      end
      if (avm_read === 1'b1 && !rst) begin
        if (beats_left > 0 || force_wait > 0 || $urandom_range(99) < stall_pct) begin
          waitreq = 1'b1;
          if (beats_left == 0 && force_wait > 0) force_wait--;
          stalled = 1'b1;
          hold_a = avm_address;
          hold_bc = avm_bc;
        end else begin
          waitreq = 1'b0;
          if (exp_cmd_addr_q.size() == 0) begin
            check("unexpected_cmd", 64'(avm_read), 64'(0));
          end else begin
            exp_a = (AW+ByteShift)'(exp_cmd_addr_q.pop_front()) << ByteShift;
            check("cmd_addr", 64'(avm_address), 64'(exp_a));
            check("cmd_len", 64'(avm_bc), 64'(exp_cmd_len_q.pop_front()));
          end
          sa = AW'(avm_address >> ByteShift);
          beats_left = int'(avm_bc);
          lat = slv_lat;
        end
      end else begin
        waitreq = 1'b0;
      end
    end
  end

  task automatic start_req(input logic [AW-1:0] a, input int lm1, input logic b);
    int guard;
    guard = 0;
    while (ready !== 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", 64'(ready), 64'(1));
    req_len = b ? lm1 + 1 : 1;
    push_model(a, req_len);
    v0 = n_valid;
    rd = 1'b1;
    burst = b;
    addr = a;
    lenm1 = 5'(lm1);
    @(negedge clk);
    rd = 1'b0;
    burst = 1'($urandom_range(1));
    check("ready_drop", 64'(ready), 64'(0));
  endtask

  task automatic finish_req();
    int guard;
    guard = 0;
    while ((exp_data_q.size() != 0 || ready !== 1'b1) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("ready_back", 64'(ready), 64'(1));
    check("leftover_words", 64'(exp_data_q.size()), 64'(0));
    check("valid_count", 64'(n_valid - v0), 64'(req_len));
  endtask

  initial begin
    logic [AW-1:0] ra;
    int guard;

    @(negedge clk);
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_data", 64'(data), 64'(0));
    check("rst_avm_read", 64'(avm_read), 64'(0));
    check("rst_avm_addr", 64'(avm_address), 64'(0));
    check("rst_avm_bc", 64'(avm_bc), 64'(0));
    rst = 1'b0;
    ena = 1'b1;
    @(negedge clk);

    // Single 4-word burst with 2-cycle slave latency.
    slv_lat = 2;
    start_req(AW'(10'h100), 3, 1'b1);
    finish_req();

    // 32 words split into two 16-word commands.
    slv_lat = 1;
    start_req(AW'(10'h040), 31, 1'b1);
    finish_req();

    // Command stalled for 5 cycles: held stable, nothing returned meanwhile.
    force_wait = 5;
    start_req(AW'(10'h200), 5, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("stall_no_valid", 64'(valid), 64'(0));
      check("stall_read", 64'(avm_read), 64'(1));
    end
    finish_req();

    // Request held while ena=0, then accepted when ena rises; ena drop mid-burst is harmless.
    ena = 1'b0;
    req_len = 12;
    push_model(AW'(10'h300), req_len);
    v0 = n_valid;
    rd = 1'b1;
    burst = 1'b1;
    addr = AW'(10'h300);
    lenm1 = 5'd11;
    repeat (4) begin
      @(negedge clk);
      check("ena0_ready", 64'(ready), 64'(1));
      check("ena0_no_read", 64'(avm_read), 64'(0));
    end
    ena = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    ena = 1'b0;
    check("ena1_accept", 64'(ready), 64'(0));
    check("ena1_read", 64'(avm_read), 64'(1));
    finish_req();
    ena = 1'b1;

    // Reset after 2 of 8 beats; the slave's remaining beats are strays.
    slv_lat = 0;
    start_req(AW'(10'h180), 7, 1'b1);
    guard = 0;
    while (n_valid - v0 < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rst_mid_seen", 64'(n_valid - v0), 64'(2));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(ready), 64'(1));
    check("mid_rst_valid", 64'(valid), 64'(0));
    check("mid_rst_data", 64'(data), 64'(0));
    check("mid_rst_read", 64'(avm_read), 64'(0));
    check("mid_rst_addr", 64'(avm_address), 64'(0));
    check("mid_rst_bc", 64'(avm_bc), 64'(0));
    exp_data_q.delete();
    exp_cmd_addr_q.delete();
    exp_cmd_len_q.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    // rd without burst is a single word.
    start_req(AW'(10'h0AA), 9, 1'b0);
    finish_req();

    // Sub-burst that wraps past the top of the address space.
    start_req(AW'(10'h3F8), 19, 1'b1);
    finish_req();

    // Randomized requests with latency, stalls and gaps.
    gap_pct = 20;
    stall_pct = 25;
    for (int n = 0; n < 1000; n++) begin
      slv_lat = $urandom_range(3);
      if ($urandom_range(3) == 0) ra = AW'((1 << AW) - 1 - $urandom_range(31));
      else ra = AW'($urandom);
      start_req(ra, $urandom_range(31), 1'($urandom_range(7) != 0));
      finish_req();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
